// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the scrambler input-conditioning block.
// Optional rise-pulse generation is controlled by DEBOUNCE_RISE_PULSE_EN.
package debounce_pkg;

    localparam int CLK_DIV_DEF   = 4;
    localparam int STEP_DIV_DEF  = 25000000;
    localparam int DB_CYCLES_DEF = 250000;
    localparam int NUM_BTN_DEF   = 2;

    // Bits needed to count 0..limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter, debounced level
// and, when DEBOUNCE_RISE_PULSE_EN is defined, a one-clk press pulse.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    // Stage p0/p1: synchronizer; only sync_p0 can go metastable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (tick) begin
            if (sync_p1 == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_db <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef DEBOUNCE_RISE_PULSE_EN
    logic btn_db_q;

    // Edge detect registered one clk after btn_db changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db_q <= 1'b0;
            btn_rise <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            btn_rise <= btn_db & ~btn_db_q;
        end
    end
`else
    assign btn_rise = 1'b0;
`endif

endmodule

// File: rtl/debounce.sv
// Scrambler front end: 25 MHz-rate enable, slow step enable and NUM_BTN debounced
// buttons, all on one clock. btn_rise is live only with DEBOUNCE_RISE_PULSE_EN.
module debounce
    import debounce_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int STEP_DIV  = STEP_DIV_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int NUM_BTN   = NUM_BTN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               clk_25_en,
    output logic               step_en,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_rise
);

    localparam int            DW       = cnt_width(CLK_DIV);
    localparam int            SW       = cnt_width(STEP_DIV);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [SW-1:0] step_cnt;
    logic          div_wrap;

    assign div_wrap = (div_cnt == DIV_MAX);

    // step_en is decided from the pre-advance step_cnt so it lands on a clk_25_en pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            step_cnt  <= '0;
            clk_25_en <= 1'b0;
            step_en   <= 1'b0;
        end else begin
            div_cnt   <= div_wrap ? '0 : div_cnt + DW'(1);
            clk_25_en <= div_wrap;
            step_en   <= div_wrap && (step_cnt == STEP_MAX);
            if (clk_25_en) begin
                step_cnt <= (step_cnt == STEP_MAX) ? '0 : step_cnt + SW'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (clk_25_en),
            .btn_raw (btn_raw[i]),
            .btn_db  (btn_db[i]),
            .btn_rise(btn_rise[i])
        );
    end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with CLK_DIV=4, STEP_DIV=5, DB_CYCLES=3, NUM_BTN=2.
// Rise-pulse expectations follow DEBOUNCE_RISE_PULSE_EN.
module tb_debounce;

`ifdef DEBOUNCE_RISE_PULSE_EN
    localparam bit RISE = 1'b1;
`else
    localparam bit RISE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       run = 1'b1;
    logic       reset;
    logic [1:0] btn_raw;
    logic       clk_25_en;
    logic       step_en;
    logic [1:0] btn_db;
    logic [1:0] btn_rise;

    int total = 0;
    int bad   = 0;
    int ecount = 0;
    int chg_k[2];
    int chg_n[2];
    int rise_k[2];
    int rise_n[2];

    debounce #(
        .CLK_DIV  (4),
        .STEP_DIV (5),
        .DB_CYCLES(3),
        .NUM_BTN  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .clk_25_en(clk_25_en),
        .step_en  (step_en),
        .btn_db   (btn_db),
        .btn_rise (btn_rise)
    );

    // Gated clock so reset can be applied with the clock stopped
    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic wait_phase(input int p);
        while (ecount % 4 != p) tick();
    endtask

    // Records when each channel's btn_db first changes and when btn_rise pulses.
    task automatic scan(input int n);
        logic [1:0] prev;
        prev = btn_db;
        for (int ch = 0; ch < 2; ch++) begin
            chg_k[ch] = 0; chg_n[ch] = 0; rise_k[ch] = 0; rise_n[ch] = 0;
        end
        for (int k = 1; k <= n; k++) begin
            tick();
            for (int ch = 0; ch < 2; ch++) begin
                if (btn_db[ch] != prev[ch]) begin
                    chg_n[ch]++;
                    if (chg_k[ch] == 0) chg_k[ch] = k;
                end
                if (btn_rise[ch]) begin
                    rise_n[ch]++;
                    if (rise_k[ch] == 0) rise_k[ch] = k;
                end
            end
            prev = btn_db;
        end
    endtask

    task automatic expect_scan(input string tag, input int ch, input int lat, input bit rising);
        check({tag, "_lat"}, chg_k[ch], lat);
        check({tag, "_nchg"}, chg_n[ch], (lat != 0) ? 1 : 0);
        check({tag, "_rise_at"}, rise_k[ch], (RISE && rising) ? lat + 1 : 0);
        check({tag, "_rise_n"}, rise_n[ch], (RISE && rising) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en25"}, int'(clk_25_en), 0);
        check({tag, "_step"}, int'(step_en), 0);
        check({tag, "_db"}, int'(btn_db), 0);
        check({tag, "_rise"}, int'(btn_rise), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int badc;
        reset   = 1'b1;
        btn_raw = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset  = 1'b0;
        ecount = 0;

        // Idle: enables at fixed cadence, buttons quiet
        badc = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            check("en25", int'(clk_25_en), int'(ecount % 4 == 0));
            check("step", int'(step_en), int'(ecount % 20 == 0));
            if (btn_db != 2'b00 || btn_rise != 2'b00) badc++;
        end
        check("idle_btn", badc, 0);

        // Press ch0 at worst-case phase: 14 clks
        wait_phase(3);
        btn_raw[0] = 1'b1;
        scan(20);
        expect_scan("press0", 0, 14, 1'b1);
        expect_scan("press0_ch1", 1, 0, 1'b0);

        // ch1 bouncing with 5-clk runs never accepted
        badc = 0;
        for (int i = 0; i < 40; i++) begin
            btn_raw[1] = ~btn_raw[1];
            repeat (5) begin
                tick();
                if (btn_db[1] || btn_rise[1]) badc++;
                if (!btn_db[0]) badc++;
            end
        end
        check("glitch1", badc, 0);

        // Release ch0: no rise pulse
        wait_phase(0);
        btn_raw[0] = 1'b0;
        scan(20);
        expect_scan("rel0", 0, 13, 1'b0);
        expect_scan("rel0_ch1", 1, 0, 1'b0);

        // Press ch1 and let it be accepted
        wait_phase(1);
        btn_raw[1] = 1'b1;
        scan(20);
        expect_scan("press1", 1, 12, 1'b1);
        expect_scan("press1_ch0", 0, 0, 1'b0);

        // ch0 mid-debounce, then reset with clock stopped
        wait_phase(2);
        btn_raw[0] = 1'b1;
        repeat (8) tick();
        check("mid_db0", int'(btn_db[0]), 0);
        check("mid_db1", int'(btn_db[1]), 1);
        @(negedge clk);
        run = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        #3;
        reset = 1'b0;
        #3;
        ecount = 0;
        run = 1'b1;
        scan(20);
        expect_scan("rst_ch0", 0, 13, 1'b1);
        expect_scan("rst_ch1", 1, 13, 1'b1);

        // Release both, then press both on the same clk
        wait_phase(0);
        btn_raw = 2'b00;
        scan(20);
        expect_scan("relboth_ch0", 0, 13, 1'b0);
        expect_scan("relboth_ch1", 1, 13, 1'b0);
        wait_phase(2);
        btn_raw = 2'b11;
        scan(20);
        expect_scan("both_ch0", 0, 11, 1'b1);
        expect_scan("both_ch1", 1, 11, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
